// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared encodings and helpers for the MEM/WB stage
package mem_wb_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam logic [1:0] WB_MEM = 2'd0;
   localparam logic [1:0] WB_ALU = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam int BE_W = 4;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   // Halfwords need an even address, words need a multiple of four; bytes are always aligned.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      return (f3[1:0] == LH[1:0] && a[0]) || (f3[1] && a != 2'b00);
   endfunction

endpackage

// File: rtl/mem_wb_stage_data_ram.sv
// data_ram: word-organised data RAM with byte-enable writes and combinational reads
module data_ram
   import mem_wb_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int VERIFY_WORD = 0,
   localparam int AW         = $clog2(DEPTH_WORDS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   i_addr,
   input  logic            i_we,
   input  logic [BE_W-1:0] i_be,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_rdata,
   output logic [XLEN-1:0] o_verify
);

   localparam int LANE = XLEN / BE_W;
   localparam logic [AW-1:0] VW = AW'(VERIFY_WORD);

   logic [XLEN-1:0] r_mem [DEPTH_WORDS];

   // Clear every word on reset; otherwise update only the enabled byte lanes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         for (int b = 0; b < BE_W; b++)
            if (i_be[b]) r_mem[i_addr][LANE*b +: LANE] <= i_wdata[LANE*b +: LANE];
      end
   end

   assign o_rdata  = r_mem[i_addr];
   assign o_verify = r_mem[VW];

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access, load latency handshake and registered write-back
module mem_wb_stage
   import mem_wb_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int MEM_LATENCY = 0,
   parameter int VERIFY_WORD = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_alu_out,
   input  logic [XLEN-1:0] ex_rs2_data,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [4:0]      ex_rd,
   input  logic            ex_reg_we,
   input  logic            ex_mem_we,
   input  logic            ex_mem_re,
   input  logic [2:0]      ex_funct3,
   input  logic [1:0]      ex_wb_sel,
   input  logic            flush,
   output logic            mem_stall,
   output logic            wb_valid,
   output logic            wb_we,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            misalign,
   output logic [XLEN-1:0] verify
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY > 0 ? MEM_LATENCY - 1 : 0);

   state_t r_state, w_state_nxt;
   logic [1:0] r_cnt, w_cnt_nxt;

   logic            r_wb_valid, r_wb_we, r_misalign;
   logic [4:0]      r_wb_rd;
   logic [XLEN-1:0] r_wb_data;

   logic            w_mis, w_in_range, w_load_go, w_cap, w_ram_we;
   logic [BE_W-1:0] w_be;
   logic [XLEN-1:0] w_wdata, w_rdata, w_word, w_sh, w_load, w_wb_data;

   assign w_mis      = (ex_mem_re | ex_mem_we) & is_misaligned(ex_funct3, ex_alu_out[1:0]);
   assign w_in_range = ~|ex_alu_out[XLEN-1:AW+2];
   assign w_load_go  = ex_valid & ex_mem_re & ~w_mis;
   assign w_cap      = ex_valid & ~mem_stall & ~flush;
   assign w_ram_we   = w_cap & ex_mem_we & ~w_mis & w_in_range;

   // Byte enables and lane-replicated store data so each lane carries rs2's low bits.
   assign w_be    = ex_funct3[1] ? 4'hF
                  : ex_funct3[0] ? 4'b0011 << {ex_alu_out[1], 1'b0}
                  : 4'b0001 << ex_alu_out[1:0];
   assign w_wdata = ex_funct3[1] ? ex_rs2_data
                  : ex_funct3[0] ? {(XLEN/16){ex_rs2_data[15:0]}}
                  : {(XLEN/8){ex_rs2_data[7:0]}};

   data_ram #(
      .XLEN        (XLEN),
      .DEPTH_WORDS (DEPTH_WORDS),
      .VERIFY_WORD (VERIFY_WORD)
   ) u_ram (
      .clk      (clk),
      .rst      (rst),
      .i_addr   (ex_alu_out[AW+1:2]),
      .i_we     (w_ram_we),
      .i_be     (w_be),
      .i_wdata  (w_wdata),
      .o_rdata  (w_rdata),
      .o_verify (verify)
   );

   // Out-of-range reads return zero; the selected lane is shifted down to bit 0 before extension.
   assign w_word = w_in_range ? w_rdata : '0;
   assign w_sh   = w_word >> {ex_alu_out[1:0], 3'b000};
   assign w_load = ex_funct3[1] ? w_word
                 : ex_funct3[0] ? {{(XLEN-16){~ex_funct3[2] & w_sh[15]}}, w_sh[15:0]}
                 : {{(XLEN-8){~ex_funct3[2] & w_sh[7]}}, w_sh[7:0]};

   assign w_wb_data = ex_wb_sel == WB_MEM ? w_load
                    : ex_wb_sel == WB_PC4 ? ex_pc + XLEN'(4)
                    : ex_alu_out;

   // Load FSM state and wait counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: enter WAIT on a stalling load, count down, and leave on flush or expiry.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (flush) begin
         w_state_nxt = S_IDLE;
      end else if (r_state == S_IDLE) begin
         if (mem_stall) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
         end
      end else if (r_cnt != 2'd0) begin
         w_cnt_nxt = r_cnt - 2'd1;
      end else begin
         w_state_nxt = S_IDLE;
      end
   end

   // Stall output: held low in reset and under flush, otherwise raised until the wait count expires.
   always_comb begin
      mem_stall = rst & ~flush & (r_state == S_IDLE ? w_load_go & (MEM_LATENCY > 0) : r_cnt != 2'd0);
   end

   // MEM/WB boundary register; misaligned accesses retire without a register write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wb_valid <= 1'b0;
         r_wb_we    <= 1'b0;
         r_misalign <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
      end else begin
         r_wb_valid <= w_cap;
         r_wb_we    <= w_cap & ex_reg_we & ~w_mis;
         r_misalign <= w_cap & w_mis;
         if (w_cap) begin
            r_wb_rd   <= ex_rd;
            r_wb_data <= w_wb_data;
         end
      end
   end

   assign wb_valid = r_wb_valid;
   assign wb_we    = r_wb_we;
   assign wb_rd    = r_wb_rd;
   assign wb_data  = r_wb_data;
   assign misalign = r_misalign;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized scoreboard bench with a byte-array memory model
module tb_mem_wb_stage;

   localparam int DEPTH = 64;
   localparam int LAT   = 2;

   logic        clk = 1'b0, rst = 1'b0;
   logic        ex_valid = 1'b0, ex_reg_we = 1'b0, ex_mem_we = 1'b0, ex_mem_re = 1'b0, flush = 1'b0;
   logic [31:0] ex_alu_out = '0, ex_rs2_data = '0, ex_pc = '0;
   logic [4:0]  ex_rd = '0;
   logic [2:0]  ex_funct3 = '0;
   logic [1:0]  ex_wb_sel = '0;
   logic        mem_stall, wb_valid, wb_we, misalign;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, verify;

   always #5 clk = ~clk;

   mem_wb_stage #(
      .XLEN(32), .DEPTH_WORDS(DEPTH), .MEM_LATENCY(LAT), .VERIFY_WORD(2)
   ) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
      .ex_rs2_data(ex_rs2_data), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
      .ex_mem_we(ex_mem_we), .ex_mem_re(ex_mem_re), .ex_funct3(ex_funct3),
      .ex_wb_sel(ex_wb_sel), .flush(flush), .mem_stall(mem_stall), .wb_valid(wb_valid),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign), .verify(verify)
   );

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        mis;
      logic        cmp_data;
   } exp_t;

   exp_t        sb[$];
   exp_t        m_e;
   logic [7:0]  mdl [DEPTH*4];
   int          checks = 0, passed = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [31:0] mdl_word(input int w);
      return {mdl[4*w+3], mdl[4*w+2], mdl[4*w+1], mdl[4*w]};
   endfunction

   function automatic int nbytes(input logic [2:0] f3);
      return f3[1] ? 4 : f3[0] ? 2 : 1;
   endfunction

   // Little-endian gather of n bytes, then sign or zero extension.
   function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [2:0] f3);
      int n;
      logic [31:0] v;
      n = nbytes(f3);
      if ((a >> 2) >= DEPTH) return 32'h0;
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mdl[a+i]) << (8*i));
      if (n < 4 && !f3[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   // Monitor: every retirement must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && wb_valid) begin
         if (sb.size() == 0) chk("wb_valid_unexpected", 32'(wb_valid), 32'h0);
         else begin
            m_e = sb.pop_front();
            chk("wb_we", 32'(wb_we), 32'(m_e.we));
            chk("wb_rd", 32'(wb_rd), 32'(m_e.rd));
            chk("misalign", 32'(misalign), 32'(m_e.mis));
            if (m_e.cmp_data) chk("wb_data", wb_data, m_e.data);
         end
      end
   end

   task automatic send(input logic re, input logic we, input logic rwe, input logic [2:0] f3,
                       input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] pc, input logic [4:0] rd, input logic fl);
      int n, stalls;
      logic st, mis;
      exp_t e;
      n   = nbytes(f3);
      mis = (re | we) && (a % n != 0);
      ex_valid = 1'b1; ex_mem_re = re; ex_mem_we = we; ex_reg_we = rwe; ex_funct3 = f3;
      ex_wb_sel = sel; ex_alu_out = a; ex_rs2_data = d; ex_pc = pc; ex_rd = rd; flush = fl;
      stalls = 0;
      while (1) begin
         #1 st = mem_stall;
         if (!st || stalls > 8) break;
         @(posedge clk);
         @(negedge clk);
         stalls++;
      end
      chk("stall_cycles", 32'(stalls), 32'((re && !mis && !fl) ? LAT : 0));
      if (!fl) begin
         e.we = rwe && !mis;
         e.rd = rd;
         e.mis = mis;
         e.cmp_data = !(mis && sel == 2'd0);
         e.data = sel == 2'd0 ? (mis ? 32'h0 : mdl_load(a, f3)) : sel == 2'd2 ? pc + 32'd4 : a;
         sb.push_back(e);
         if (we && !mis && (a >> 2) < DEPTH)
            for (int i = 0; i < n; i++) mdl[a+i] = d[8*i +: 8];
      end
      @(posedge clk);
      @(negedge clk);
      ex_valid = 1'b0;
      flush = 1'b0;
      chk("wb_valid_latency", 32'(wb_valid), 32'(!fl));
      chk("verify", verify, mdl_word(2));
   endtask

   // Start an aligned load, then kill it mid-WAIT with flush (kind 0) or reset (kind 1).
   task automatic abort_load(input int kind);
      ex_valid = 1'b1; ex_mem_re = 1'b1; ex_mem_we = 1'b0; ex_reg_we = 1'b1; ex_funct3 = 3'b010;
      ex_wb_sel = 2'd0; ex_alu_out = 32'd16; ex_rd = 5'd3; flush = 1'b0;
      #1 chk("abort_stall_t0", 32'(mem_stall), 32'h1);
      @(posedge clk);
      @(negedge clk);
      chk("abort_stall_t1", 32'(mem_stall), 32'h1);
      if (kind == 0) begin
         flush = 1'b1;
         #1 chk("flush_stall", 32'(mem_stall), 32'h0);
         @(posedge clk);
         @(negedge clk);
         chk("flush_wb_valid", 32'(wb_valid), 32'h0);
         flush = 1'b0;
         ex_valid = 1'b0;
      end else begin
         rst = 1'b0;
         ex_valid = 1'b0;
         #1;
         chk("rst_wb_valid", 32'(wb_valid), 32'h0);
         chk("rst_wb_we", 32'(wb_we), 32'h0);
         chk("rst_wb_rd", 32'(wb_rd), 32'h0);
         chk("rst_wb_data", wb_data, 32'h0);
         chk("rst_misalign", 32'(misalign), 32'h0);
         chk("rst_mem_stall", 32'(mem_stall), 32'h0);
         chk("rst_verify", verify, 32'h0);
         for (int i = 0; i < DEPTH*4; i++) mdl[i] = 8'h00;
         @(posedge clk);
         @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         chk("rst_release_wb_valid", 32'(wb_valid), 32'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [2:0]  f3;
      logic [31:0] a;
      int          k;
      for (int i = 0; i < DEPTH*4; i++) mdl[i] = 8'h00;
      repeat (2) @(negedge clk);
      chk("reset_wb_valid", 32'(wb_valid), 32'h0);
      chk("reset_wb_we", 32'(wb_we), 32'h0);
      chk("reset_wb_data", wb_data, 32'h0);
      chk("reset_misalign", 32'(misalign), 32'h0);
      chk("reset_mem_stall", 32'(mem_stall), 32'h0);
      chk("reset_verify", verify, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      //      re    we    rwe   f3      sel   addr   data           pc        rd     flush
      send(1'b0, 1'b1, 1'b0, 3'b010, 2'd1, 32'd8, 32'hDEADBEEF, 32'h0,    5'd0,  1'b0);
      send(1'b1, 1'b0, 1'b1, 3'b000, 2'd0, 32'd9, 32'h0,        32'h4,    5'd5,  1'b0);
      send(1'b1, 1'b0, 1'b1, 3'b100, 2'd0, 32'd9, 32'h0,        32'h8,    5'd6,  1'b0);
      send(1'b1, 1'b0, 1'b1, 3'b001, 2'd0, 32'd10, 32'h0,       32'hC,    5'd7,  1'b0);
      send(1'b1, 1'b0, 1'b1, 3'b010, 2'd0, 32'd8, 32'h0,        32'h10,   5'd8,  1'b0);
      send(1'b0, 1'b1, 1'b0, 3'b000, 2'd1, 32'd8, 32'h00000055, 32'h14,   5'd0,  1'b0);
      send(1'b1, 1'b0, 1'b1, 3'b010, 2'd0, 32'd8, 32'h0,        32'h18,   5'd9,  1'b0);
      send(1'b1, 1'b0, 1'b1, 3'b010, 2'd0, 32'd6, 32'h0,        32'h1C,   5'd10, 1'b0);
      send(1'b0, 1'b1, 1'b0, 3'b001, 2'd1, 32'd3, 32'h0000AAAA, 32'h20,   5'd0,  1'b0);
      send(1'b1, 1'b0, 1'b1, 3'b010, 2'd0, 32'd0, 32'h0,        32'h24,   5'd11, 1'b0);
      send(1'b0, 1'b1, 1'b0, 3'b010, 2'd1, 32'd8, 32'h12345678, 32'h28,   5'd0,  1'b1);
      send(1'b0, 1'b1, 1'b0, 3'b010, 2'd1, 32'h400, 32'hCAFEF00D, 32'h2C, 5'd0,  1'b0);
      send(1'b1, 1'b0, 1'b1, 3'b010, 2'd0, 32'h400, 32'h0,      32'h30,   5'd12, 1'b0);
      for (int i = 0; i < 4; i++)
         send(1'b0, 1'b0, 1'b1, 3'b000, 2'd1, 32'(i * 7 + 1), 32'h0, 32'h40, 5'(i + 1), 1'b0);
      abort_load(0);
      send(1'b1, 1'b0, 1'b1, 3'b010, 2'd0, 32'd8, 32'h0,        32'h50,   5'd13, 1'b0);
      abort_load(1);
      send(1'b0, 1'b0, 1'b1, 3'b000, 2'd2, 32'h0, 32'h0,        32'h100,  5'd1,  1'b0);
      send(1'b0, 1'b0, 1'b1, 3'b000, 2'd2, 32'h0, 32'h0,        32'hFFFFFFFC, 5'd2, 1'b0);
      send(1'b0, 1'b1, 1'b0, 3'b010, 2'd1, 32'd8, 32'h0BADCAFE, 32'h104,  5'd0,  1'b0);
      send(1'b1, 1'b0, 1'b1, 3'b010, 2'd0, 32'd8, 32'h0,        32'h108,  5'd14, 1'b0);
      for (int it = 0; it < 300; it++) begin
         k = $urandom_range(0, 9);
         a = ($urandom_range(0, 9) == 0) ? 32'(256 + $urandom_range(0, 63)) : 32'($urandom_range(0, 63));
         if (k < 3) begin
            f3 = 3'($urandom_range(0, 2));
            send(1'b0, 1'b1, 1'b0, f3, 2'd1, a, $urandom, $urandom, 5'($urandom), $urandom_range(0, 15) == 0);
         end else if (k < 7) begin
            f3 = ld_f3[$urandom_range(0, 4)];
            send(1'b1, 1'b0, 1'b1, f3, 2'($urandom_range(0, 3)), a, $urandom, $urandom, 5'($urandom), $urandom_range(0, 15) == 0);
         end else begin
            send(1'b0, 1'b0, 1'($urandom), 3'b000, 2'($urandom_range(1, 3)), $urandom, $urandom, $urandom, 5'($urandom), $urandom_range(0, 15) == 0);
         end
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
